stopwatch_counter: RTL

Timekeeping core of the stopwatch. It turns two button levels (start/stop, clear) into a run/pause/clear state machine. It divides the board clock into a 1 Hz count tick and keeps a four-digit BCD mm:ss value. Its `bcd_num` output feeds the 7-segment scan driver directly: digit 3 is minute tens, down to digit 0, which is second units.

---
 rtl/stopwatch_counter.sv | 133 +++++++++++++
 1 files changed

// File: rtl/stopwatch_counter.sv
// mm:ss stopwatch core: button edge detect, 1 Hz prescaler, BCD digit chain and
// IDLE/RUN/PAUSE/FULL control. state_o exposes the FSM (0 IDLE, 1 RUN, 2 PAUSE, 3 FULL).
module stopwatch_counter #(
    parameter int CLK_HZ  = 12_000_000,
    parameter int TICK_HZ = 1,
    parameter bit WRAP    = 1'b0
) (
    input  logic        clk12mhz,
    input  logic        rst,
    input  logic        start_stop,
    input  logic        clear,
    output logic [15:0] bcd_num,
    output logic        running,
    output logic        full,
    output logic [1:0]  state_o
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        FULL  = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [PW-1:0]  presc_q, presc_d;
    logic [3:0]     su_q, su_d;
    logic [3:0]     st_q, st_d;
    logic [3:0]     mu_q, mu_d;
    logic [3:0]     mt_q, mt_d;
    logic           ss_prev_q, clr_prev_q;

    logic ss_evt, clr_evt, tick, at_max;

    assign ss_evt  = start_stop & ~ss_prev_q;
    assign clr_evt = clear & ~clr_prev_q;
    assign tick    = (state_q == RUN) && (presc_q == PRESC_MAX);
    assign at_max  = (mt_q == 4'd5) && (mu_q == 4'd9) && (st_q == 4'd5) && (su_q == 4'd9);

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        su_d    = su_q;
        st_d    = st_q;
        mu_d    = mu_q;
        mt_d    = mt_q;
        if (clr_evt) begin
            state_d = IDLE;
            presc_d = '0;
            su_d    = 4'd0;
            st_d    = 4'd0;
            mu_d    = 4'd0;
            mt_d    = 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    presc_d = '0;
                    if (ss_evt) state_d = RUN;
                end
                RUN: begin
                    if (tick) begin
                        presc_d = '0;
                        if (at_max) begin
                            if (WRAP) begin
                                su_d = 4'd0;
                                st_d = 4'd0;
                                mu_d = 4'd0;
                                mt_d = 4'd0;
                            end else begin
                                state_d = FULL;
                            end
                        end else if (su_q != 4'd9) begin
                            su_d = su_q + 4'd1;
                        end else begin
                            su_d = 4'd0;
                            if (st_q != 4'd5) begin
                                st_d = st_q + 4'd1;
                            end else begin
                                st_d = 4'd0;
                                if (mu_q != 4'd9) begin
                                    mu_d = mu_q + 4'd1;
                                end else begin
                                    mu_d = 4'd0;
                                    mt_d = mt_q + 4'd1;
                                end
                            end
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                    // A press on the tick edge still lets the count advance, then pauses.
                    if (ss_evt) state_d = PAUSE;
                end
                PAUSE: begin
                    if (ss_evt) state_d = RUN;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk12mhz) begin
        if (rst) begin
            state_q    <= IDLE;
            presc_q    <= '0;
            su_q       <= 4'd0;
            st_q       <= 4'd0;
            mu_q       <= 4'd0;
            mt_q       <= 4'd0;
            ss_prev_q  <= 1'b1;
            clr_prev_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            su_q       <= su_d;
            st_q       <= st_d;
            mu_q       <= mu_d;
            mt_q       <= mt_d;
            ss_prev_q  <= start_stop;
            clr_prev_q <= clear;
        end
    end

    assign bcd_num = {mt_q, mu_q, st_q, su_q};
    assign running = (state_q == RUN);
    assign full    = (state_q == FULL);
    assign state_o = state_q;

endmodule
